// File: rtl/control_link_sequencer.sv
// control_link_sequencer: queues register commands and runs them one at a time on a link master.
// Latency: a command pushed into an empty FIFO with the sequencer idle raises m_initiateRequest 2 cycles later.
// Backpressure: cmd_ready drops while the command FIFO is full; an unconsumed response blocks the next issue.
module control_link_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        byte_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_address,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        m_initiateRequest,
    output logic        m_requestIsWrite,
    output logic [15:0] m_address,
    output logic [31:0] m_dataOut,
    output logic        m_reset,
    input  logic        m_busy,
    input  logic        m_done,
    input  logic        m_error,
    input  logic [31:0] m_dataIn
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] dat;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RELEASE,
        RECOVER,
        RESP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    cmd_t          r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    cmd_t          w_push_cmd;

    cmd_t          r_hold;
    logic [31:0]   r_rsp_data;
    logic          r_tmo_flag;
    logic          r_err_flag;
    logic [TW-1:0] r_tmo_cnt;
    logic [TW-1:0] w_tmo_inc;
    logic          w_tmo_hit;
    logic          r_rec_cnt;

    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = cmd_valid && !w_full;
    assign w_push_cmd = {cmd_write, cmd_address, cmd_data};
    assign cmd_ready  = !w_full;

    // Timeout fires when the incremented wait count reaches TIMEOUT_CYCLES, so WAIT_DONE lasts at most TIMEOUT_CYCLES cycles.
    assign w_tmo_inc  = r_tmo_cnt + TW'(1);
    assign w_tmo_hit  = (w_tmo_inc == TW'(TIMEOUT_CYCLES));

    assign m_address        = r_hold.addr;
    assign m_dataOut        = r_hold.dat;
    assign m_requestIsWrite = r_hold.wr;
    assign rsp_data         = r_rsp_data;
    assign rsp_status       = {r_err_flag, r_tmo_flag};

    // Command FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge byte_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_cmd;
        end
    end

    // Command FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge byte_clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge byte_clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, FIFO pop and the state-decoded master/response strobes.
    always_comb begin
        w_state_nxt       = r_state;
        w_pop             = 1'b0;
        m_initiateRequest = 1'b0;
        m_reset           = 1'b0;
        rsp_valid         = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !m_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                m_initiateRequest = 1'b1;
                w_state_nxt       = WAIT_DONE;
            end
            WAIT_DONE: begin
                m_initiateRequest = 1'b1;
                if (m_done) begin
                    w_state_nxt = RELEASE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = RECOVER;
                end
            end
            RELEASE: begin
                if (!m_done) begin
                    w_state_nxt = RESP;
                end
            end
            RECOVER: begin
                m_reset = 1'b1;
                if (r_rec_cnt) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Holding registers, timeout/recovery counters and the response being built for the current transaction.
    always_ff @(posedge byte_clk) begin
        if (reset) begin
            r_hold     <= '0;
            r_rsp_data <= '0;
            r_tmo_flag <= 1'b0;
            r_err_flag <= 1'b0;
            r_tmo_cnt  <= '0;
            r_rec_cnt  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_hold <= r_mem[r_rd_ptr];
            end
            case (r_state)
                ISSUE: begin
                    r_tmo_cnt  <= '0;
                    r_tmo_flag <= 1'b0;
                    r_err_flag <= m_error;
                    r_rec_cnt  <= 1'b0;
                end
                WAIT_DONE: begin
                    r_err_flag <= r_err_flag | m_error;
                    if (m_done) begin
                        r_rsp_data <= r_hold.wr ? 32'h0 : m_dataIn;
                    end else begin
                        r_tmo_cnt <= w_tmo_inc;
                        if (w_tmo_hit) begin
                            r_tmo_flag <= 1'b1;
                            r_rsp_data <= 32'h0;
                        end
                    end
                end
                RECOVER: begin
                    r_rec_cnt <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/control_link_sequencer.md
CONTROL_LINK_SEQUENCER -- requirements
Module: control_link_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2).
- TIMEOUT_CYCLES, 1023, WAIT_DONE cycles before abort.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- byte_clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous, active-high.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command FIFO not full.
- cmd_write, in, 1, 1=write, 0=read.
- cmd_address, in, 16, register address.
- cmd_data, in, 32, write data.
- rsp_valid, out, 1, response held.
- rsp_ready, in, 1, response consumed.
- rsp_data, out, 32, read data (0 for writes and aborts).
- rsp_status, out, 2, bit0=timeout, bit1=link error seen.
- m_initiateRequest, out, 1, to master initiateRequest.
- m_requestIsWrite, out, 1, to master requestIsWrite.
- m_address, out, 16, to master address.
- m_dataOut, out, 32, to master dataOut.
- m_reset, out, 1, master recovery reset.
- m_busy, in, 1, from master busy.
- m_done, in, 1, from master done.
- m_error, in, 1, from master error.
- m_dataIn, in, 32, from master dataIn.
REQ-003 Clocking SHALL be one clock, byte_clk; reset SHALL be synchronous and active-high, named reset.

Function
REQ-004 Command FIFO: push on cmd_valid&&cmd_ready; cmd_ready = !full; pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-005 Push and pop in the same cycle SHALL leave the count unchanged; when full there is no push; when empty there is no pop.
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT_DONE, RELEASE, RECOVER, RESP.
REQ-007 IDLE with FIFO non-empty and m_busy=0: pop into the holding registers (write, address, data) -> ISSUE.
REQ-008 A command pushed in cycle N into an empty FIFO, with the FSM idle, SHALL produce m_initiateRequest=1 in cycle N+2.
REQ-009 m_initiateRequest SHALL be 1 exactly in ISSUE and WAIT_DONE.
REQ-010 m_address, m_dataOut and m_requestIsWrite SHALL be driven from the holding registers and stay stable from ISSUE through RELEASE.
REQ-011 ISSUE SHALL last one cycle, clear the timeout counter and the error flag, then -> WAIT_DONE.
REQ-012 WAIT_DONE with m_done=1: capture rsp_data = write ? 0 : m_dataIn -> RELEASE.
REQ-013 WAIT_DONE with m_done=0: increment the timeout counter; when the counter equals TIMEOUT_CYCLES, set status bit0, set rsp_data=0 -> RECOVER.
REQ-014 RELEASE: hold m_initiateRequest=0; wait for m_done=0 -> RESP.
REQ-015 RECOVER: m_reset=1 for exactly 2 cycles -> RESP; m_reset SHALL be 0 in all other states.
REQ-016 The error flag (status bit1) SHALL be set if m_error=1 in any cycle from ISSUE to exit of WAIT_DONE; it does not abort the transaction.
REQ-017 RESP: rsp_valid=1 with rsp_data and rsp_status stable; on rsp_ready=1 -> IDLE.
REQ-018 Only one transaction SHALL be outstanding at a time; the FIFO SHALL keep accepting commands while a transaction is active.

Reset
REQ-019 On reset=1 the FSM SHALL go to IDLE, the FIFO SHALL be emptied, and outputs SHALL be: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_status=0, m_initiateRequest=0, m_reset=0, m_address=0, m_dataOut=0, m_requestIsWrite=0.
REQ-020 Reset in any state, including mid-transaction, SHALL discard the transaction and queued commands with no response; m_reset SHALL NOT be asserted by reset itself.

Verification
REQ-021 Write 0x0012<-0xDEADBEEF, master m_done at cycle N+10 -> m_initiateRequest 1 from N+2 to N+10; rsp_valid with rsp_data=0, rsp_status=0.
REQ-022 Read 0x0034, m_dataIn=0xCAFEF00D at m_done -> rsp_data=0xCAFEF00D, rsp_status=0; m_initiateRequest drops the cycle after m_done.
REQ-023 Push 5 commands back-to-back with FIFO_DEPTH=4 and master stalled -> cmd_ready=0 after the FIFO fills; all 5 execute in push order; 5 responses.
REQ-024 Master never asserts m_done, TIMEOUT_CYCLES=15 -> m_reset high 2 cycles; rsp_status=2'b01, rsp_data=0; next command proceeds normally.
REQ-025 m_error pulse during WAIT_DONE, read completes with 0x00000001 -> rsp_status=2'b10, rsp_data=0x00000001.
REQ-026 reset asserted in WAIT_DONE with 2 commands queued -> next cycle: IDLE, FIFO empty, m_initiateRequest=0, no rsp_valid.
